// File: rtl/key_event.sv
// ---------------------------------------------------------------------------
// key_event
// Key-gesture decoder fed by the 100 Hz key debouncer. Converts one debounced
// key level into single-cycle events for the front-panel controller: press,
// release, short click, long press and auto-repeat while held. A saturating
// repeat count lets the controller accelerate its step size.
//
// Parameters
//   ACTIVE_LOW  1: key_in==0 means pressed; 0: key_in==1 means pressed
//   TICK_DIV    clk cycles per 1 ms tick
//   LONG_MS     ticks of hold before long_pulse (1..65535)
//   REPEAT_MS   ticks between repeat_pulse events after long_pulse (1..65535)
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   key_in         in   debounced key level (slow domain, synchronised here)
//   held           out  key currently pressed (after synchroniser)
//   press_pulse    out  1-cycle pulse on press edge
//   release_pulse  out  1-cycle pulse on release edge
//   click_pulse    out  1-cycle pulse on release before the long threshold
//   long_pulse     out  1-cycle pulse when the hold reaches LONG_MS
//   repeat_pulse   out  1-cycle pulse every REPEAT_MS after long_pulse
//   repeat_cnt     out  repeats in the current hold, saturates at 255
// ---------------------------------------------------------------------------
module key_event #(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned LONG_MS    = 800,
  parameter int unsigned REPEAT_MS  = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [7:0] repeat_cnt
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [15:0]   LONG_LAST   = 16'(LONG_MS - 1);
  localparam logic [15:0]   REPEAT_LAST = 16'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRESS  = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  // Input path, all in "pressed = 1" polarity
  logic          pressed_s;
  logic          sync1_q;
  logic          sync2_q;
  logic          kprev_q;
  logic          rise_s;
  logic          fall_s;

  // 1 ms time base
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_s;

  // Gesture FSM and registered outputs
  state_e        state_q;
  logic [15:0]   ms_cnt_q;
  logic [7:0]    repeat_cnt_q;
  logic          held_q;
  logic          press_q;
  logic          release_q;
  logic          click_q;
  logic          long_q;
  logic          repeat_q;

  assign pressed_s = key_in ^ ACTIVE_LOW;
  assign rise_s    = sync2_q & ~kprev_q;
  assign fall_s    = ~sync2_q & kprev_q;
  assign tick_s    = (presc_q == PRESC_MAX);

  // Prescaler next value: restarts on a press so the hold is timed from the press itself
  always_comb begin
    presc_d = presc_q;
    if (rise_s) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Two-stage synchroniser, edge-detect history and prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Released level, so a key held through reset produces a press afterwards
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      kprev_q <= 1'b0;
      presc_q <= '0;
    end else begin
      sync1_q <= pressed_s;
      sync2_q <= sync1_q;
      kprev_q <= sync2_q;
      presc_q <= presc_d;
    end
  end

  // Gesture FSM with registered level, pulse and count outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ms_cnt_q     <= 16'd0;
      repeat_cnt_q <= 8'd0;
      held_q       <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      click_q      <= 1'b0;
      long_q       <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      held_q    <= sync2_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // repeat_cnt keeps the last hold's value until the next press
          if (rise_s) begin
            press_q      <= 1'b1;
            ms_cnt_q     <= 16'd0;
            repeat_cnt_q <= 8'd0;
            state_q      <= S_PRESS;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PRESS: begin
          // A release on the threshold tick still counts as a click
          if (fall_s) begin
            release_q <= 1'b1;
            click_q   <= 1'b1;
            state_q   <= S_IDLE;
          end else if (tick_s && (ms_cnt_q == LONG_LAST)) begin
            long_q   <= 1'b1;
            ms_cnt_q <= 16'd0;
            state_q  <= S_REPEAT;
          end else if (tick_s) begin
            ms_cnt_q <= ms_cnt_q + 16'd1;
          end else begin
            ms_cnt_q <= ms_cnt_q;
          end
        end
        S_REPEAT: begin
          if (fall_s) begin
            release_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (tick_s && (ms_cnt_q == REPEAT_LAST)) begin
            repeat_q <= 1'b1;
            ms_cnt_q <= 16'd0;
            if (repeat_cnt_q != 8'hFF) begin
              repeat_cnt_q <= repeat_cnt_q + 8'd1;
            end else begin
              repeat_cnt_q <= repeat_cnt_q;
            end
          end else if (tick_s) begin
            ms_cnt_q <= ms_cnt_q + 16'd1;
          end else begin
            ms_cnt_q <= ms_cnt_q;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ms_cnt_q <= 16'd0;
        end
      endcase
    end
  end

  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign repeat_cnt    = repeat_cnt_q;

endmodule

// File: tb/tb_key_event.sv
// ---------------------------------------------------------------------------
// tb_key_event
// Directed bench for key_event (TICK_DIV=10, LONG_MS=5, REPEAT_MS=2).
// A reference model expresses the gesture rules as elapsed clock cycles since
// the press (long at 50, repeats every 20 after that), independent of any
// prescaler/state encoding, and is compared against the DUT every cycle.
// Literal expectations per scenario pin the model. A second instance with
// ACTIVE_LOW=0 covers the non-inverted key polarity.
// ---------------------------------------------------------------------------
module tb_key_event;

  localparam int LONG_CLK = 50;  // LONG_MS * TICK_DIV
  localparam int REP_CLK  = 20;  // REPEAT_MS * TICK_DIV

  logic       clk;
  logic       rst;
  logic       key_in;
  logic       held, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;
  logic [7:0] repeat_cnt;

  logic       key2;
  logic       held2, press2, rel2, click2, long2, rep2;
  logic [7:0] rcnt2;

  int n_checks = 0;
  int n_fail   = 0;

  key_event #(.ACTIVE_LOW(1'b1), .TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(2)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .click_pulse(click_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .repeat_cnt(repeat_cnt)
  );

  key_event #(.ACTIVE_LOW(1'b0), .TICK_DIV(10), .LONG_MS(5), .REPEAT_MS(2)) dut2 (
    .clk(clk), .rst(rst), .key_in(key2),
    .held(held2), .press_pulse(press2), .release_pulse(rel2),
    .click_pulse(click2), .long_pulse(long2),
    .repeat_pulse(rep2), .repeat_cnt(rcnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_rep(input int e);
    return (e > LONG_CLK) && (((e - LONG_CLK) % REP_CLK) == 0);
  endfunction

  // ---------------- reference model ----------------
  // m_h1..m_h3: pressed level seen at the last three edges
  logic m_h1, m_h2, m_h3;
  logic m_held, m_press, m_rel, m_click, m_long, m_rep, m_active;
  int   m_el;
  int   m_rcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h1 <= 1'b0; m_h2 <= 1'b0; m_h3 <= 1'b0;
      m_held <= 1'b0; m_press <= 1'b0; m_rel <= 1'b0; m_click <= 1'b0;
      m_long <= 1'b0; m_rep <= 1'b0; m_active <= 1'b0;
      m_el <= 0; m_rcnt <= 0;
    end else begin
      m_h1    <= ~key_in;
      m_h2    <= m_h1;
      m_h3    <= m_h2;
      m_held  <= m_h2;
      m_press <= m_h2 & ~m_h3;
      m_rel   <= ~m_h2 & m_h3;
      m_click <= ~m_h2 & m_h3 & ((m_el + 1) <= LONG_CLK);
      m_long  <= m_h2 & m_active & ((m_el + 1) == LONG_CLK);
      m_rep   <= m_h2 & m_active & is_rep(m_el + 1);
      if (m_h2 & ~m_h3) begin
        m_el     <= 0;
        m_rcnt   <= 0;
        m_active <= 1'b1;
      end else if (m_h2 & m_active) begin
        m_el <= m_el + 1;
        if (is_rep(m_el + 1) && (m_rcnt < 255)) m_rcnt <= m_rcnt + 1;
      end else if (~m_h2 & m_h3) begin
        m_active <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of the main instance against the model
  always @(negedge clk) begin
    chk("held",          held,          m_held);
    chk("press_pulse",   press_pulse,   m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("click_pulse",   click_pulse,   m_click);
    chk("long_pulse",    long_pulse,    m_long);
    chk("repeat_pulse",  repeat_pulse,  m_rep);
    chk("repeat_cnt",    repeat_cnt,    m_rcnt);
  end

  // ---------------- event counters for literal checks ----------------
  int cyc;
  int c_press, c_rel, c_click, c_long, c_rep, c_held;
  int t_press, t_rel, t_click, t_long;

  task automatic clr();
    c_press = 0; c_rel = 0; c_click = 0; c_long = 0; c_rep = 0; c_held = 0;
    t_press = -1; t_rel = -1; t_click = -1; t_long = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (press_pulse)   begin c_press++; t_press = cyc; end
      if (release_pulse) begin c_rel++;   t_rel   = cyc; end
      if (click_pulse)   begin c_click++; t_click = cyc; end
      if (long_pulse)    begin c_long++;  t_long  = cyc; end
      if (repeat_pulse)  c_rep++;
      if (held)          c_held++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_held"},  held,          0);
    chk({tag, "_press"}, press_pulse,   0);
    chk({tag, "_rel"},   release_pulse, 0);
    chk({tag, "_click"}, click_pulse,   0);
    chk({tag, "_long"},  long_pulse,    0);
    chk({tag, "_rep"},   repeat_pulse,  0);
    chk({tag, "_rcnt"},  repeat_cnt,    0);
  endtask

  initial begin
    int found;
    cyc    = 0;
    rst    = 1'b1;
    key_in = 1'b1;
    key2   = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #1 rst = 1'b0;
    run(5);

    // 1: short press of 20 clk -> click
    clr();
    key_in = 1'b0; run(20);
    key_in = 1'b1; run(30);
    chk("t1_press", c_press, 1);
    chk("t1_release", c_rel, 1);
    chk("t1_click", c_click, 1);
    chk("t1_long", c_long, 0);
    chk("t1_held_cycles", c_held, 20);
    chk("t1_click_with_release", t_click - t_rel, 0);
    chk("t1_hold_len", t_rel - t_press, 20);

    // 2: hold 200 clk -> long at 50, 7 repeats, no click
    clr();
    key_in = 1'b0; run(200);
    key_in = 1'b1; run(30);
    chk("t2_press", c_press, 1);
    chk("t2_long", c_long, 1);
    chk("t2_long_delay", t_long - t_press, 50);
    chk("t2_repeats", c_rep, 7);
    chk("t2_repeat_cnt", repeat_cnt, 7);
    chk("t2_release", c_rel, 1);
    chk("t2_click", c_click, 0);

    // 3: release coincides with the tick completing the long threshold
    clr();
    key_in = 1'b0; run(50);
    key_in = 1'b1; run(30);
    chk("t3_long", c_long, 0);
    chk("t3_click", c_click, 1);
    chk("t3_release", c_rel, 1);
    chk("t3_repeats", c_rep, 0);
    chk("t3_hold_len", t_rel - t_press, 50);

    // 4: very long hold -> repeat_cnt saturates, pulses continue
    clr();
    key_in = 1'b0; run(5300);
    chk("t4_repeat_cnt_sat", repeat_cnt, 255);
    key_in = 1'b1; run(30);
    chk("t4_repeats", c_rep, 262);
    chk("t4_repeat_cnt_kept", repeat_cnt, 255);

    // 5: async reset mid-REPEAT with key still pressed
    clr();
    key_in = 1'b0; run(100);
    chk("t5_pre_rcnt", repeat_cnt, 2);
    chk("t5_pre_held", held, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("t5_async");
    @(negedge clk);
    #1 rst = 1'b0;
    found = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      cyc++;
      if (press_pulse) begin
        found = n;
        break;
      end
    end
    chk("t5_press_latency", found, 3);
    chk("t5_rcnt_cleared", repeat_cnt, 0);
    run(100);
    chk("t5_rcnt_restart", repeat_cnt, 2);
    key_in = 1'b1; run(30);

    // 6: ACTIVE_LOW=0 instance, key_in 0->1
    key2 = 1'b1;
    @(negedge clk);
    chk("t6_press_e0", press2, 0);
    @(negedge clk);
    chk("t6_press_e1", press2, 0);
    chk("t6_held_e1", held2, 0);
    @(negedge clk);
    chk("t6_press_e2", press2, 1);
    chk("t6_held_e2", held2, 1);
    @(negedge clk);
    chk("t6_press_e3", press2, 0);
    chk("t6_held_e3", held2, 1);
    key2 = 1'b0;
    found = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rel2) found++;
    end
    chk("t6_release", found, 1);
    chk("t6_long", long2, 0);
    chk("t6_rep", rep2, 0);
    chk("t6_click", click2, 0);
    chk("t6_rcnt", rcnt2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
